// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divided-clock controller.
// State encoding, minimum legal ratio and default counter width.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV   = 2;
  localparam int unsigned CNT_W_DEF = 32;

endpackage

// File: rtl/div_ctrl_cnt.sv
// Period counter: wraps at div-1, raises tick on the last cycle, and registers
// the half-period compare so the divided clock leaves a flop.
module div_ctrl_cnt
  import div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             active_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             run_nxt_i,
  input  logic [CNT_W-1:0] div_nxt_i,
  output logic             tick_o,
  output logic             clk_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;

  assign tick_o = active_i && (cnt_q == (div_i - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Evaluated against the next count and next ratio so the flop matches cnt.
  assign clk_d = run_nxt_i && (cnt_d < (div_nxt_i >> 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk_o = clk_q;

endmodule

// File: rtl/div_ctrl.sv
// Programmable clock divider with glitch-free ratio change at period wrap.
// Optional tick counter output enabled by DIV_CTRL_TICKCNT_EN.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 100000000
) (
  input  logic             I_CLK,
  input  logic             I_RSTN,
  input  logic             I_START,
  input  logic             I_STOP,
  input  logic             I_CFG_VALID,
  input  logic [CNT_W-1:0] I_CFG_DIV,
  output logic             O_CFG_READY,
  output logic             O_TICK,
  output logic             O_CLK,
  output logic             O_BUSY,
`ifdef DIV_CTRL_TICKCNT_EN
  output logic [15:0]      O_TICK_CNT,
`endif
  output logic             O_CFG_ERR
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             err_q, err_d;
  logic             cnt_en, cnt_clr, tick;
  logic             cfg_acc, cfg_ok, start_acc;

  assign O_CFG_READY = (state_q != PEND);
  assign O_BUSY      = (state_q != IDLE);
  assign O_CFG_ERR   = err_q;
  assign O_TICK      = tick;

  assign cfg_acc   = I_CFG_VALID && O_CFG_READY;
  assign cfg_ok    = (I_CFG_DIV >= CNT_W'(MIN_DIV));
  assign start_acc = (state_q == IDLE) && I_START && !I_STOP;

  always_comb begin
    state_d    = state_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    err_d      = err_q;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (cfg_acc) begin
          if (cfg_ok) begin
            div_act_d = I_CFG_DIV;
            err_d     = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        if (start_acc) state_d = RUN;
      end
      RUN: begin
        if (I_STOP) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (cfg_acc) begin
            if (cfg_ok) begin
              div_pend_d = I_CFG_DIV;
              err_d      = 1'b0;
              state_d    = PEND;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      PEND: begin
        // The pending ratio is kept even when stopped early.
        if (I_STOP) begin
          state_d   = IDLE;
          cnt_clr   = 1'b1;
          div_act_d = div_pend_q;
        end else begin
          cnt_en = 1'b1;
          if (tick) begin
            div_act_d = div_pend_q;
            state_d   = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state_q    <= IDLE;
      div_act_q  <= CNT_W'(DEFAULT_DIV);
      div_pend_q <= CNT_W'(DEFAULT_DIV);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      err_q      <= err_d;
    end
  end

  div_ctrl_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i    (I_CLK),
    .rst_ni   (I_RSTN),
    .active_i (state_q != IDLE),
    .en_i     (cnt_en),
    .clr_i    (cnt_clr),
    .div_i    (div_act_q),
    .run_nxt_i(state_d != IDLE),
    .div_nxt_i(div_act_d),
    .tick_o   (tick),
    .clk_o    (O_CLK)
  );

`ifdef DIV_CTRL_TICKCNT_EN
  logic [15:0] tick_cnt_q;

  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      tick_cnt_q <= '0;
    end else if (start_acc) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  assign O_TICK_CNT = tick_cnt_q;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: vector table, corner-case sequences, random vs reference.
module tb_div_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, stop = 1'b0, cvld = 1'b0;
  logic [W-1:0] cdiv = '0;
  logic         rdy, tick, oclk, busy, err;
`ifdef DIV_CTRL_TICKCNT_EN
  logic [15:0]  tcnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  div_ctrl #(.CNT_W(W), .DEFAULT_DIV(4)) dut (
    .I_CLK      (clk),
    .I_RSTN     (rst_n),
    .I_START    (start),
    .I_STOP     (stop),
    .I_CFG_VALID(cvld),
    .I_CFG_DIV  (cdiv),
    .O_CFG_READY(rdy),
    .O_TICK     (tick),
    .O_CLK      (oclk),
    .O_BUSY     (busy),
`ifdef DIV_CTRL_TICKCNT_EN
    .O_TICK_CNT (tcnt),
`endif
    .O_CFG_ERR  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sp;
    logic        cv;
    int          cd;
    logic [4:0]  exp;   // {tick, clk, busy, ready, err}
  } vec_t;

  vec_t tbl[20];

  // Reference: whole-period view with integer position and ratios.
  int m_run, m_pend, m_pos, m_ratio, m_nratio, m_err, m_tc;

  function automatic logic [4:0] outs();
    return {tick, oclk, busy, rdy, err};
  endfunction

  function automatic logic [4:0] model_outs();
    logic t, c;
    t = (m_run != 0) && (m_pos == m_ratio - 1);
    c = (m_run != 0) && (m_pos < m_ratio / 2);
    return {t, c, m_run != 0, m_pend == 0, m_err != 0};
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_pos = 0; m_ratio = 4; m_nratio = 4; m_err = 0; m_tc = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit cv, input int cd);
    bit was_tick;
    was_tick = (m_run != 0) && (m_pos == m_ratio - 1);
    if (m_run == 0 && st && !sp) m_tc = 0;
    else if (was_tick) m_tc = (m_tc + 1) % 65536;
    if (m_run == 0) begin
      if (cv) begin
        if (cd >= 2) begin m_ratio = cd; m_err = 0; end
        else m_err = 1;
      end
      if (st && !sp) begin m_run = 1; m_pos = 0; end
    end else if (sp) begin
      m_run = 0; m_pos = 0;
      if (m_pend != 0) m_ratio = m_nratio;
      m_pend = 0;
    end else begin
      bit acc;
      acc = cv && (m_pend == 0);
      if (was_tick) begin
        m_pos = 0;
        if (m_pend != 0) begin m_ratio = m_nratio; m_pend = 0; end
      end else begin
        m_pos++;
      end
      if (acc) begin
        if (cd >= 2) begin m_nratio = cd; m_pend = 1; m_err = 0; end
        else m_err = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    start = 0; stop = 0; cvld = 0; cdiv = '0;
    rst_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // Steps until O_TICK is observed; returns cycle label or -1 on timeout.
  task automatic wait_tick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (tick) begin
        at = cyc + 1;
        return;
      end
    end
  endtask

  initial begin
    int s, t1, t2, t3, nt;

    tbl[0]  = '{1, 0, 0, 0, 5'b01110};
    tbl[1]  = '{0, 0, 0, 0, 5'b01110};
    tbl[2]  = '{0, 0, 0, 0, 5'b00110};
    tbl[3]  = '{0, 0, 0, 0, 5'b10110};
    tbl[4]  = '{0, 0, 0, 0, 5'b01110};
    tbl[5]  = '{0, 0, 1, 1, 5'b01111};
    tbl[6]  = '{0, 0, 0, 0, 5'b00111};
    tbl[7]  = '{0, 0, 0, 0, 5'b10111};
    tbl[8]  = '{0, 0, 1, 5, 5'b01100};
    tbl[9]  = '{0, 0, 0, 0, 5'b01100};
    tbl[10] = '{0, 0, 0, 0, 5'b00100};
    tbl[11] = '{0, 0, 0, 0, 5'b10100};
    tbl[12] = '{0, 0, 0, 0, 5'b01110};
    tbl[13] = '{0, 0, 0, 0, 5'b01110};
    tbl[14] = '{0, 0, 0, 0, 5'b00110};
    tbl[15] = '{0, 0, 0, 0, 5'b00110};
    tbl[16] = '{0, 0, 0, 0, 5'b10110};
    tbl[17] = '{0, 1, 0, 0, 5'b00010};
    tbl[18] = '{1, 1, 0, 0, 5'b00010};
    tbl[19] = '{0, 0, 0, 0, 5'b00010};

    // Reset values while reset is held.
    rst_n = 0;
    #2;
    chk("reset_outs", int'(outs()), int'(5'b00010));
    do_reset();
    chk("post_reset_outs", int'(outs()), int'(5'b00010));

    // Vector table: start, wave shape, illegal cfg, pending cfg N=5, stop, start+stop.
    for (int i = 0; i < 20; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; cvld = tbl[i].cv; cdiv = W'(tbl[i].cd);
      step();
      start = 0; stop = 0; cvld = 0;
      chk($sformatf("vec%0d", i), int'(outs()), int'(tbl[i].exp));
    end

    // Ratio change from 4 to 6 accepted at cnt=1.
    do_reset();
    start = 1; s = cyc + 1; step(); start = 0;
    step();
    cvld = 1; cdiv = 16'd6; step(); cvld = 0;
    chk("pend_ready_low", int'(rdy), 0);
    wait_tick(20, t1);
    chk("first_interval_4", t1 - s, 4);
    step();
    chk("ready_after_wrap", int'(rdy), 1);
    wait_tick(20, t2);
    wait_tick(20, t3);
    chk("interval_6a", t2 - t1, 6);
    chk("interval_6b", t3 - t2, 6);

    // Stop while a ratio of 8 is pending; next run uses it.
    do_reset();
    start = 1; step(); start = 0;
    cvld = 1; cdiv = 16'd8; step(); cvld = 0;
    chk("pend8_ready", int'(rdy), 0);
    stop = 1; step(); stop = 0;
    chk("stop_in_pend_busy", int'(busy), 0);
    start = 1; s = cyc + 1; step(); start = 0;
    wait_tick(30, t1);
    chk("interval_after_stop", t1 - s, 8);

    // Asynchronous reset between edges.
    do_reset();
    start = 1; step(); start = 0;
    chk("pre_async_clk_busy", int'({oclk, busy}), 3);
    #3;
    rst_n = 0;
    #1;
    chk("async_rst_outs", int'({tick, oclk, busy}), 0);
    step(); step();
    rst_n = 1;
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) nt++;
    end
    chk("no_tick_after_rst", nt, 0);
    chk("idle_after_rst", int'(busy), 0);

    // Randomized run against the reference.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bit st, sp, cv;
      int cd;
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 29) == 0);
      cv = ($urandom_range(0, 7) == 0);
      cd = $urandom_range(0, 7);
      chk($sformatf("rand%0d", i), int'(outs()), int'(model_outs()));
`ifdef DIV_CTRL_TICKCNT_EN
      chk($sformatf("rand_tcnt%0d", i), int'(tcnt), m_tc);
`endif
      start = st; stop = sp; cvld = cv; cdiv = W'(cd);
      model_edge(st, sp, cv, cd);
      step();
    end
    start = 0; stop = 0; cvld = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of divide ratio and period counter.
REQ-002 Parameter DEFAULT_DIV, default 100000000: active ratio after reset; SHALL be >= 2.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 I_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 I_RSTN  input  1  asynchronous active-low reset.
REQ-006 I_START  input  1  level; in IDLE, begins running.
REQ-007 I_STOP  input  1  level; in RUN/PEND, returns to IDLE.
REQ-008 I_CFG_VALID  input  1  new ratio offered.
REQ-009 I_CFG_DIV  input  CNT_W  requested ratio N (period in I_CLK cycles).
REQ-010 O_CFG_READY  output  1  config accepted when VALID&READY.
REQ-011 O_TICK  output  1  one-cycle strobe, once per period.
REQ-012 O_CLK  output  1  registered divided square wave.
REQ-013 O_BUSY  output  1  high when state != IDLE.
REQ-014 O_CFG_ERR  output  1  sticky illegal-ratio flag.

Function
REQ-015 FSM states IDLE, RUN, PEND; counter cnt in 0..div_act-1; registers div_act, div_pend.
REQ-016 IDLE: I_START and not I_STOP -> RUN next cycle, cnt=0; START and STOP same cycle -> remain IDLE.
REQ-017 RUN/PEND: cnt increments each cycle; at cnt==div_act-1, O_TICK=1 that cycle, cnt wraps to 0 next cycle.
REQ-018 First O_TICK occurs exactly div_act cycles after the cycle I_START is sampled.
REQ-019 O_CLK==1 iff cnt < (div_act>>1) in RUN/PEND; 0 in IDLE; odd N gives low phase one cycle longer.
REQ-020 O_CFG_READY = 1 in IDLE and RUN, 0 in PEND.
REQ-021 Accepted cfg with I_CFG_DIV < 2: no ratio change, O_CFG_ERR set; handshake still completes.
REQ-022 Accepted legal cfg in IDLE: div_act loads next cycle; clears O_CFG_ERR.
REQ-023 Accepted legal cfg in RUN: div_pend loads, -> PEND; clears O_CFG_ERR.
REQ-024 PEND at wrap: div_act <= div_pend, -> RUN; new ratio governs the next full period; no truncated period.
REQ-025 Cfg and START same cycle in IDLE: both take effect; first period uses new ratio.
REQ-026 I_STOP in RUN/PEND (wins over wrap and cfg): -> IDLE, cnt=0, O_CLK=0; in PEND, div_pend copied to div_act.
REQ-027 cnt comparison uses CNT_W-bit unsigned arithmetic; no overflow since cnt < div_act.

Reset
REQ-028 I_RSTN low: immediately, without clock edge, state=IDLE, cnt=0, div_act=DEFAULT_DIV, div_pend=DEFAULT_DIV.
REQ-029 Reset outputs: O_TICK=0, O_CLK=0, O_BUSY=0, O_CFG_ERR=0, O_CFG_READY=1.
REQ-030 Reset mid-run or mid-PEND discards pending ratio; no tick after release until new START.

Configuration
REQ-031 Macro DIV_CTRL_TICKCNT_EN defined: output O_TICK_CNT (16 bits) counts O_TICK pulses, wraps 0xFFFF->0, cleared by reset and accepted START.
REQ-032 Macro undefined: O_TICK_CNT port and logic absent; all other behaviour identical.

Structure
REQ-033 Package div_ctrl_pkg holds state encoding (IDLE/RUN/PEND), MIN_DIV=2 constant, CNT_W default.
REQ-034 One sub-module div_ctrl_cnt: period counter with wrap and half-period compare, driven by FSM enable/clear.

Verification
REQ-035 DEFAULT_DIV=4, START at cycle 10 -> O_TICK at cycles 14, 18, 22; O_CLK 1,1,0,0 per period.
REQ-036 Running N=4, cfg N=6 accepted at cnt=1 -> READY low until wrap; tick intervals 4 then 6, 6.
REQ-037 Cfg N=1 -> O_CFG_ERR=1, tick interval unchanged; then cfg N=5 -> O_CFG_ERR=0, O_CLK high 2 low 3.
REQ-038 START+STOP same cycle in IDLE -> O_BUSY stays 0; STOP in PEND (pending 8) -> IDLE, next START gives interval 8.
REQ-039 I_RSTN low mid-period between clock edges -> O_CLK, O_TICK, O_BUSY 0 immediately; after release, no tick without START.
REQ-040 With DIV_CTRL_TICKCNT_EN, N=2, 65537 ticks -> O_TICK_CNT=1; START clears to 0.
